// File: rtl/bru_pred.sv
`default_nettype none
// ============================================================================
// Module   : bru_pred
// Purpose  : EX-stage branch resolution with a bimodal 2-bit BHT for IF.
//            Optional performance counters are enabled by BRU_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bru_pred #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [XLEN-1:0]  if_pc_i,
    output logic             pred_taken_o,
    input  logic             ex_valid_i,
    input  logic [XLEN-1:0]  ex_pc_i,
    input  logic [XLEN-1:0]  ex_target_i,
    input  logic             ex_pred_taken_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic             is_br_i,
    input  logic             is_uncbr_i,
    input  logic [2:0]       func3_i,
    output logic             pc_sel_o,
    output logic             mispredict_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int              IDX_W    = $clog2(BHT_DEPTH);
    localparam logic [XLEN-1:0] c_pc_inc = XLEN'(4);

    logic [XLEN:0]      w_diff;
    logic               w_eq;
    logic               w_ltu;
    logic               w_ovf;
    logic               w_lt;
    logic               w_cond;
    logic               w_f3_valid;
    logic               w_taken;
    logic               w_bht_we;
    logic [IDX_W-1:0]   w_ex_idx;
    logic [IDX_W-1:0]   w_if_idx;
    logic [1:0]         w_bht_cur;
    logic [1:0]         w_bht_nxt;
    logic               w_unused;
    logic [1:0]         r_bht [BHT_DEPTH];

    // Single subtractor serves all six conditions: rs1 - rs2 with carry-out.
    assign w_diff = {1'b0, rs1_data_i} + {1'b0, ~rs2_data_i} + {{XLEN{1'b0}}, 1'b1};
    assign w_eq   = (w_diff[XLEN-1:0] == '0);
    assign w_ltu  = ~w_diff[XLEN];
    assign w_ovf  = (rs1_data_i[XLEN-1] ^ rs2_data_i[XLEN-1]) &
                    (w_diff[XLEN-1] ^ rs1_data_i[XLEN-1]);
    assign w_lt   = w_diff[XLEN-1] ^ w_ovf;

    always_comb begin
        w_cond     = 1'b0;
        w_f3_valid = 1'b1;
        case (func3_i)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = ~w_eq;
            3'b100:  w_cond = w_lt;
            3'b101:  w_cond = ~w_lt;
            3'b110:  w_cond = w_ltu;
            3'b111:  w_cond = ~w_ltu;
            default: w_f3_valid = 1'b0;
        endcase
    end

    assign w_taken       = ex_valid_i & (is_uncbr_i | (is_br_i & w_cond));
    assign pc_sel_o      = w_taken;
    assign mispredict_o  = ex_valid_i & (is_br_i | is_uncbr_i) & (w_taken != ex_pred_taken_i);
    assign redirect_pc_o = w_taken ? ex_target_i : (ex_pc_i + c_pc_inc);

    assign w_ex_idx  = ex_pc_i[IDX_W+1:2];
    assign w_if_idx  = if_pc_i[IDX_W+1:2];
    assign w_bht_we  = ex_valid_i & is_br_i & ~is_uncbr_i & w_f3_valid;
    assign w_bht_cur = r_bht[w_ex_idx];
    // Only the lookup index bits of the fetch PC matter.
    assign w_unused  = ^if_pc_i;

    always_comb begin
        w_bht_nxt = w_bht_cur;
        if (w_taken) begin
            if (w_bht_cur != 2'b11) w_bht_nxt = w_bht_cur + 2'b01;
        end else begin
            if (w_bht_cur != 2'b00) w_bht_nxt = w_bht_cur - 2'b01;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
        end else if (w_bht_we) begin
            r_bht[w_ex_idx] <= w_bht_nxt;
        end
    end

    // No bypass: a same-cycle write to this index is seen next cycle.
    assign pred_taken_o = r_bht[w_if_idx][1];

`ifdef BRU_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             w_br_evt;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    assign w_br_evt = ex_valid_i & ((is_br_i & w_f3_valid) | is_uncbr_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_br_evt && (r_br_cnt != '1))          r_br_cnt      <= r_br_cnt + c_cnt_one;
            if (mispredict_o && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + c_cnt_one;
        end
    end

    assign br_cnt_o      = r_br_cnt;
    assign mispred_cnt_o = r_mispred_cnt;
`else
    assign br_cnt_o      = '0;
    assign mispred_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bru_pred.sv
`default_nettype none
// ============================================================================
// Module   : tb_bru_pred
// Purpose  : Self-checking bench for bru_pred against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bru_pred;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     if_pc;
    logic            pred_taken;
    logic            ex_valid;
    logic [31:0]     ex_pc;
    logic [31:0]     ex_target;
    logic            ex_pred;
    logic [31:0]     rs1;
    logic [31:0]     rs2;
    logic            is_br;
    logic            is_unc;
    logic [2:0]      f3;
    logic            pc_sel;
    logic            mispred;
    logic [31:0]     redir;
    logic [CW-1:0]   br_cnt;
    logic [CW-1:0]   mis_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    int          mdl_bht [DEPTH];
    int unsigned mdl_br;
    int unsigned mdl_mis;

    always #5 clk = ~clk;

    bru_pred #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .if_pc_i         (if_pc),
        .pred_taken_o    (pred_taken),
        .ex_valid_i      (ex_valid),
        .ex_pc_i         (ex_pc),
        .ex_target_i     (ex_target),
        .ex_pred_taken_i (ex_pred),
        .rs1_data_i      (rs1),
        .rs2_data_i      (rs2),
        .is_br_i         (is_br),
        .is_uncbr_i      (is_unc),
        .func3_i         (f3),
        .pc_sel_o        (pc_sel),
        .mispredict_o    (mispred),
        .redirect_pc_o   (redir),
        .br_cnt_o        (br_cnt),
        .mispred_cnt_o   (mis_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl_bht[i] = 1;
        mdl_br  = 0;
        mdl_mis = 0;
    endtask

    // Branch condition straight from the ISA definition.
    function automatic bit cond_of(input logic [2:0] c, input logic [31:0] a,
                                   input logic [31:0] b, output bit ok);
        ok = 1'b1;
        case (c)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: begin ok = 1'b0; return 1'b0; end
        endcase
    endfunction

    // Compare all outputs against the model, then advance the model by one edge.
    task automatic compare_and_update();
        bit          ok;
        bit          cnd;
        bit          tk;
        bit          mp;
        logic [31:0] rd;
        int          ei;
        cnd = cond_of(f3, rs1, rs2, ok);
        tk  = ex_valid && (is_unc || (is_br && cnd));
        mp  = ex_valid && (is_br || is_unc) && (tk != ex_pred);
        rd  = tk ? ex_target : ex_pc + 32'd4;
        check("pc_sel", {31'b0, pc_sel}, {31'b0, tk});
        check("mispredict", {31'b0, mispred}, {31'b0, mp});
        check("redirect_pc", redir, rd);
        check("pred_taken", {31'b0, pred_taken}, {31'b0, mdl_bht[if_pc[7:2]] >= 2});
`ifdef BRU_PERF_CNT_EN
        check("br_cnt", {24'b0, br_cnt}, mdl_br);
        check("mispred_cnt", {24'b0, mis_cnt}, mdl_mis);
`else
        check("br_cnt", {24'b0, br_cnt}, 32'd0);
        check("mispred_cnt", {24'b0, mis_cnt}, 32'd0);
`endif
        ei = int'(ex_pc[7:2]);
        if (ex_valid && is_br && !is_unc && ok) begin
            if (tk) mdl_bht[ei] = (mdl_bht[ei] == 3) ? 3 : mdl_bht[ei] + 1;
            else    mdl_bht[ei] = (mdl_bht[ei] == 0) ? 0 : mdl_bht[ei] - 1;
        end
        if (ex_valid && ((is_br && ok) || is_unc) && mdl_br < CMAX) mdl_br++;
        if (mp && mdl_mis < CMAX) mdl_mis++;
    endtask

    task automatic step();
        #1;
        compare_and_update();
        @(negedge clk);
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic [31:0] tg,
                          input logic pr, input logic [31:0] a, input logic [31:0] b,
                          input logic br, input logic un, input logic [2:0] c);
        ex_valid = v; ex_pc = pc; ex_target = tg; ex_pred = pr;
        rs1 = a; rs2 = b; is_br = br; is_unc = un; f3 = c;
    endtask

    task automatic random_cycles(input int n);
        logic [31:0] ext [5];
        int          r;
        ext[0] = 32'h0; ext[1] = 32'h1; ext[2] = 32'h7FFF_FFFF;
        ext[3] = 32'h8000_0000; ext[4] = 32'hFFFF_FFFF;
        for (int k = 0; k < n; k++) begin
            ex_valid  = ($urandom % 8) != 0;
            ex_pc     = ($urandom & 32'hFFFF_FF00) | (($urandom % 8) << 2);
            if ($urandom % 16 == 0) ex_pc = 32'hFFFF_FFFC;
            ex_target = $urandom & 32'hFFFF_FFFC;
            ex_pred   = 1'($urandom % 2);
            f3        = 3'($urandom % 8);
            rs1       = $urandom;
            case ($urandom % 4)
                0: rs2 = $urandom;
                1: rs2 = rs1;
                2: begin rs1 = ext[$urandom % 5]; rs2 = ext[$urandom % 5]; end
                default: rs2 = ($urandom % 2) ? rs1 + 32'd1 : rs1 - 32'd1;
            endcase
            r = int'($urandom % 10);
            is_br  = (r <= 5) || (r == 7);
            is_unc = (r == 6) || (r == 7);
            if_pc  = ($urandom & 32'hFFFF_FF00) | (($urandom % 8) << 2);
            step();
        end
    endtask

    initial begin
        int unsigned b0;
        int unsigned m0;
        rst_n = 1'b0;
        if_pc = 32'h0;
        set_ex(1'b0, 32'h200, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state: every counter weakly not taken.
        for (int i = 0; i < DEPTH; i++) begin
            if_pc = i * 4;
            #1;
            check("reset_pred", {31'b0, pred_taken}, 32'd0);
        end
        @(negedge clk);
        if_pc = 32'h0;
        #1;
        check("reset_br_cnt", {24'b0, br_cnt}, 32'd0);
        check("reset_mis_cnt", {24'b0, mis_cnt}, 32'd0);
        check("idle_pc_sel", {31'b0, pc_sel}, 32'd0);
        check("idle_redirect", redir, 32'h204);
        step();

        // Signed vs unsigned compare of -1 and 1.
        set_ex(1'b1, 32'h100, 32'h800, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 3'b100);
        #1;
        check("blt_pc_sel", {31'b0, pc_sel}, 32'd1);
        check("blt_mispredict", {31'b0, mispred}, 32'd1);
        check("blt_redirect", redir, 32'h800);
        step();
        set_ex(1'b1, 32'h100, 32'h800, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 3'b110);
        #1;
        check("bltu_pc_sel", {31'b0, pc_sel}, 32'd0);
        check("bltu_redirect", redir, 32'h104);
        step();
        set_ex(1'b1, 32'h104, 32'h900, 1'b0, 32'd5, 32'd5, 1'b1, 1'b0, 3'b101);
        #1;
        check("bge_eq_pc_sel", {31'b0, pc_sel}, 32'd1);
        step();
        set_ex(1'b1, 32'h108, 32'h900, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'b111);
        #1;
        check("bgeu_pc_sel", {31'b0, pc_sel}, 32'd0);
        step();

        // Invalid func3 at index 16 must leave the counter at 01.
        if_pc = 32'h40;
        set_ex(1'b1, 32'h40, 32'h400, 1'b0, 32'd3, 32'd3, 1'b1, 1'b0, 3'b010);
        #1;
        check("f3_010_pc_sel", {31'b0, pc_sel}, 32'd0);
        step();

        // Four taken BEQs: 01 -> 10 -> 11 -> 11, no same-cycle bypass.
        for (int k = 0; k < 4; k++) begin
            set_ex(1'b1, 32'h40, 32'h400, 1'b1, 32'd7, 32'd7, 1'b1, 1'b0, 3'b000);
            #1;
            check("beq_train_pred", {31'b0, pred_taken}, (k == 0) ? 32'd0 : 32'd1);
            step();
        end

        // JAL on an untrained index must not train it.
        b0 = mdl_br; m0 = mdl_mis;
        if_pc = 32'h80;
        set_ex(1'b1, 32'h80, 32'h1000, 1'b0, 32'd1, 32'd2, 1'b0, 1'b1, 3'b000);
        #1;
        check("jal_mispredict", {31'b0, mispred}, 32'd1);
        check("jal_redirect", redir, 32'h1000);
        step();
        set_ex(1'b0, 32'h80, 32'h1000, 1'b0, 32'd1, 32'd2, 1'b0, 1'b0, 3'b000);
        #1;
        check("jal_no_train", {31'b0, pred_taken}, 32'd0);
`ifdef BRU_PERF_CNT_EN
        check("jal_br_cnt", {24'b0, br_cnt}, b0 + 1);
        check("jal_mis_cnt", {24'b0, mis_cnt}, m0 + 1);
`endif
        step();

        random_cycles(3000);
`ifdef BRU_PERF_CNT_EN
        #1;
        check("br_cnt_saturated", {24'b0, br_cnt}, CMAX);
        @(negedge clk);
`endif

        // Retrain index 16 to 11, then reset asynchronously mid-cycle.
        if_pc = 32'h40;
        for (int k = 0; k < 3; k++) begin
            set_ex(1'b1, 32'h40, 32'h400, 1'b1, 32'd9, 32'd9, 1'b1, 1'b0, 3'b000);
            step();
        end
        set_ex(1'b0, 32'h40, 32'h400, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'b000);
        #1;
        check("pre_reset_pred", {31'b0, pred_taken}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_pred", {31'b0, pred_taken}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        random_cycles(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bru_pred.md
# bru_pred

Parametrised branch resolution unit with a built-in bimodal predictor for the 5-stage pipeline. It resolves conditional branches and jumps in EX and flags mispredictions against the prediction carried down the pipe. It also supplies the redirect PC and trains a table of 2-bit saturating counters that IF reads for the next prediction. Optional performance counters track resolved and mispredicted control transfers.

## Interface
- XLEN, 32: data/PC width (≥ 8).
- BHT_DEPTH, 64: number of 2-bit counters; power of two, ≥ 2. IDX_W = log2(BHT_DEPTH).
- CNT_W, 32: performance counter width.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- if_pc_i  in  XLEN  fetch PC for lookup.
- pred_taken_o  out  1  MSB of counter at index if_pc_i[IDX_W+1:2].
- ex_valid_i  in  1  EX holds a live instruction.
- ex_pc_i  in  XLEN  PC of EX instruction.
- ex_target_i  in  XLEN  computed branch/jump target.
- ex_pred_taken_i  in  1  prediction made in IF for this instruction.
- rs1_data_i, rs2_data_i  in  XLEN  operands.
- is_br_i, is_uncbr_i  in  1  conditional branch / jump.
- func3_i  in  3  branch condition.
- pc_sel_o  out  1  actual taken.
- mispredict_o  out  1  flush request.
- redirect_pc_o  out  XLEN  correct next PC.
- br_cnt_o, mispred_cnt_o  out  CNT_W  performance counters.

## Operation
- Compare: diff = rs1 + ~rs2 + 1 at XLEN+1 bits. eq = (diff[XLEN-1:0] == 0). ltu = ~carry. lt = diff[XLEN-1] ^ signed overflow.
- Conditions: 000 BEQ eq, 001 BNE ~eq, 100 BLT lt, 101 BGE ~lt, 110 BLTU ltu, 111 BGEU ~ltu. Codes 010/011 are invalid: not taken, no BHT update.
- taken = ex_valid_i & (is_uncbr_i | (is_br_i & cond)). is_uncbr_i has priority when both are set.
- pc_sel_o = taken.
- mispredict_o = ex_valid_i & (is_br_i | is_uncbr_i) & (taken != ex_pred_taken_i).
- redirect_pc_o = taken ? ex_target_i : ex_pc_i + 4, modulo 2^XLEN.
- BHT index = PC[IDX_W+1:2]. Every counter resets to 2'b01 (weakly not taken).
- BHT update occurs when ex_valid_i & is_br_i & ~is_uncbr_i & valid func3. Taken increments, saturating at 11. Not taken decrements, saturating at 00.
- Jumps never train the BHT.
- Same-cycle read and write of the same index: pred_taken_o returns the old value. There is no bypass.
- Index aliasing is allowed; no tag check is performed.

## Timing
- pc_sel_o, mispredict_o, redirect_pc_o and pred_taken_o are combinational, with zero-cycle latency.
- A BHT write lands on the clock edge and is visible to pred_taken_o in the next cycle.
- Performance counters update on the clock edge after the event.
- Reset values:
  - All counters are 01, so pred_taken_o = 0.
  - br_cnt_o = mispred_cnt_o = 0.
  - With ex_valid_i = 0: pc_sel_o = 0, mispredict_o = 0, redirect_pc_o = ex_pc_i + 4.
- Reset asserted mid-operation clears the BHT and counters immediately. Any in-flight update is lost.

## Configuration
- BRU_PERF_CNT_EN defined:
  - br_cnt_o increments on each ex_valid_i & (valid is_br_i | is_uncbr_i).
  - mispred_cnt_o increments on each mispredict_o.
  - Both saturate at all-ones.
- BRU_PERF_CNT_EN undefined: no counter flops are built, and both outputs are tied to 0.

## Test plan
- Reset with rst_ni low, then release: pred_taken_o = 0 for every if_pc_i, and both counters read 0.
- BLT with rs1 = 0xFFFFFFFF, rs2 = 1, pred 0: pc_sel_o = 1, mispredict_o = 1, redirect_pc_o = ex_target_i. The same operands under BLTU give pc_sel_o = 0, and redirect_pc_o = 0x104 for ex_pc_i = 0x100.
- BGE with equal operands (5, 5): taken. BGEU with 0 vs 0xFFFFFFFF: not taken. func3 = 010: not taken, and the BHT is unchanged.
- Four taken BEQs at ex_pc_i = 0x40 (index 16):
  - counter sequence is 01 → 10 → 11 → 11;
  - pred_taken_o at if_pc_i = 0x40 rises the cycle after the first update;
  - a same-cycle read during the first update returns 0.
- JAL (is_uncbr_i = 1, pred 0): mispredict_o = 1 and redirect_pc_o = target; BHT is untouched. With BRU_PERF_CNT_EN, both counters increment by 1. Counters preset at all-ones hold their value.
- Assert rst_ni low mid-sequence after training index 16 to 11: pred_taken_o drops to 0 asynchronously, before the next clock edge.
